// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - scale encodings and default raster constants shared by the video blocks
package video_pkg;

    localparam logic [1:0] SCALE_1X = 2'd0;
    localparam logic [1:0] SCALE_2X = 2'd1;
    localparam logic [1:0] SCALE_4X = 2'd2;

    localparam int DEFAULT_WIDTH       = 1024;
    localparam int DEFAULT_HEIGHT      = 768;
    localparam int DEFAULT_PIXEL_WIDTH = 24;

    // Code 3 is not a distinct factor; it replicates like 4x.
    function automatic logic [1:0] scale_shift(input logic [1:0] code);
        return (code == 2'd3) ? SCALE_4X : code;
    endfunction

endpackage

// File: rtl/frame_buffer_scaler_if.sv
// rtl/frame_buffer_scaler_if.sv - pixel write bus and video stream bundle
interface frame_buffer_scaler_if
    import video_pkg::*;
#(
    parameter int AddrWidth  = 20,
    parameter int PixelWidth = DEFAULT_PIXEL_WIDTH
);

    logic                  WrEn;
    logic [AddrWidth-1:0]  WrAddr;
    logic [PixelWidth-1:0] WrData;
    logic [PixelWidth-1:0] Video;
    logic                  VideoValid;
    logic                  VideoReady;
    logic                  FrameStart;

    modport master (
        input  WrEn, WrAddr, WrData, VideoReady,
        output Video, VideoValid, FrameStart
    );

    modport slave (
        output WrEn, WrAddr, WrData, VideoReady,
        input  Video, VideoValid, FrameStart
    );

endinterface

// File: rtl/frame_buffer_ram.sv
// rtl/frame_buffer_ram.sv - simple dual-port pixel RAM with registered read-first read
module frame_buffer_ram
    import video_pkg::*;
#(
    parameter int Depth     = 24000,
    parameter int DataWidth = DEFAULT_PIXEL_WIDTH,
    parameter int AddrBits  = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AddrBits-1:0]  wr_addr,
    input  logic [DataWidth-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [AddrBits-1:0]  rd_addr,
    output logic [DataWidth-1:0] rd_data
);

    logic [DataWidth-1:0] mem [Depth];

    // Both ports in one process: a same-address read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/frame_buffer_scaler.sv
// rtl/frame_buffer_scaler.sv - frame store streaming a replicated-scale raster on a ready/valid port
module frame_buffer_scaler
    import video_pkg::*;
#(
    parameter int Width      = DEFAULT_WIDTH,
    parameter int Height     = DEFAULT_HEIGHT,
    parameter int PixelWidth = DEFAULT_PIXEL_WIDTH,
    parameter int BufferSize = 24000,
    parameter int AddrWidth  = 20,
    parameter logic [PixelWidth-1:0] FillColor = PixelWidth'(24'hFFFFFF)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [1:0]            Scale,
    output logic [15:0]           WrDropCount,
    frame_buffer_scaler_if.master vif
);

    localparam int XW  = $clog2(Width);
    localparam int YW  = $clog2(Height);
    localparam int RAW = $clog2(BufferSize);

    localparam logic [AddrWidth:0]   BUF_LIMIT = (AddrWidth + 1)'(BufferSize);
    localparam logic [AddrWidth-1:0] STRIDE    = AddrWidth'(Width);
    localparam logic [XW-1:0]        X_LAST    = XW'(Width - 1);
    localparam logic [YW-1:0]        Y_LAST    = YW'(Height - 1);

    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [1:0]            scale_q, scale_d;
    logic                  pend_q, pend_d;
    logic                  pend_fill_q, pend_fill_d;
    logic                  pend_fs_q, pend_fs_d;
    logic                  out_valid_q, out_valid_d;
    logic [PixelWidth-1:0] out_data_q, out_data_d;
    logic                  out_fs_q, out_fs_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [PixelWidth-1:0] skid_data_q, skid_data_d;
    logic                  skid_fs_q, skid_fs_d;
    logic [15:0]           drop_q, drop_d;

    logic                  at_origin;
    logic [1:0]            shift;
    logic [AddrWidth-1:0]  x_src, y_src, src;
    logic                  src_fill;
    logic [RAW-1:0]        ram_raddr;
    logic [PixelWidth-1:0] ram_rdata;
    logic [PixelWidth-1:0] arr_data;
    logic [1:0]            occ_next;
    logic                  issue, pop;
    logic                  wr_in_range, wr_ok;

    // Write path: in-range writes land in RAM, out-of-range ones are only counted.
    always_comb begin
        wr_in_range = ({1'b0, vif.WrAddr} < BUF_LIMIT);
        wr_ok       = vif.WrEn && wr_in_range;
        drop_d      = drop_q;
        if (vif.WrEn && !wr_in_range && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    frame_buffer_ram #(
        .Depth     (BufferSize),
        .DataWidth (PixelWidth),
        .AddrBits  (RAW)
    ) u_ram (
        .clk     (Clock),
        .wr_en   (wr_ok),
        .wr_addr (vif.WrAddr[RAW-1:0]),
        .wr_data (vif.WrData),
        .rd_en   (issue),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    // Stage A: raster walk, scale latch at (0,0), source address and read issue.
    always_comb begin
        pop       = out_valid_q && vif.VideoReady;
        // Slots still owed next cycle; the read issued now needs one of the two.
        occ_next  = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(pend_q) - 2'(pop);
        issue     = (occ_next < 2'd2);
        at_origin = (x_q == '0) && (y_q == '0);
        shift     = at_origin ? scale_shift(Scale) : scale_q;
        x_src     = AddrWidth'(x_q) >> shift;
        y_src     = AddrWidth'(y_q) >> shift;
        src       = y_src * STRIDE + x_src;
        src_fill  = ({1'b0, src} >= BUF_LIMIT);
        ram_raddr = src_fill ? '0 : src[RAW-1:0];

        x_d         = x_q;
        y_d         = y_q;
        scale_d     = scale_q;
        pend_d      = issue;
        pend_fill_d = src_fill;
        pend_fs_d   = issue && at_origin;
        if (issue) begin
            if (at_origin) begin
                scale_d = shift;
            end
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Stage B: output register fed from the skid entry first, then from the RAM.
    always_comb begin
        arr_data     = pend_fill_q ? FillColor : ram_rdata;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_fs_d     = out_fs_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_fs_d    = skid_fs_q;
        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_fs_d     = skid_fs_q;
                skid_valid_d = pend_q;
                skid_data_d  = pend_q ? arr_data : skid_data_q;
                skid_fs_d    = pend_q && pend_fs_q;
            end else if (pend_q) begin
                out_valid_d = 1'b1;
                out_data_d  = arr_data;
                out_fs_d    = pend_fs_q;
            end else begin
                out_valid_d = 1'b0;
                out_fs_d    = 1'b0;
            end
        end else if (pend_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = arr_data;
            skid_fs_d    = pend_fs_q;
        end
    end

    // State registers; reset flushes the pipeline and restarts the raster.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            x_q          <= '0;
            y_q          <= '0;
            scale_q      <= SCALE_1X;
            pend_q       <= 1'b0;
            pend_fill_q  <= 1'b0;
            pend_fs_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= FillColor;
            out_fs_q     <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= FillColor;
            skid_fs_q    <= 1'b0;
            drop_q       <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            scale_q      <= scale_d;
            pend_q       <= pend_d;
            pend_fill_q  <= pend_fill_d;
            pend_fs_q    <= pend_fs_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_fs_q     <= out_fs_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_fs_q    <= skid_fs_d;
            drop_q       <= drop_d;
        end
    end

    assign vif.Video      = out_data_q;
    assign vif.VideoValid = out_valid_q;
    assign vif.FrameStart = out_fs_q;
    assign WrDropCount    = drop_q;

endmodule
